product_bcd_conv: RTL and testbench

PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

---
 rtl/product_bcd_conv.sv | 96 +++++++++
 tb/tb_product_bcd_conv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter: turns an unsigned W-bit product into D packed BCD digits,
// one bit per cycle, with valid/ready handshakes on both sides.
module product_bcd_conv #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [4*D-1:0]  scratch_q, scratch_d;
  logic [4*D-1:0]  scratch_adj;
  logic [4*D-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;

  // Pre-shift correction: any digit that would reach 10+ after doubling is bumped by 3.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_adj
      assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                      ? scratch_q[4*gi +: 4] + 4'd3
                                      : scratch_q[4*gi +: 4];
    end
  endgenerate

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {scratch_adj[4*D-2:0], shift_q[W-1]};
        shift_d   = {shift_q[W-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          bcd_d       = {scratch_adj[4*D-2:0], shift_q[W-1]};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv: handshake timing, backpressure, reset abort and a full 0..255 sweep.
module tb_product_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;

  product_bcd_conv #(.W(8), .D(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dec_digits(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Offers v for one cycle, then waits (bounded) for out_valid; lat = edges after accept, -1 on timeout.
  // Leaves the bench on the negedge where out_valid was first seen.
  task automatic start_and_wait(input logic [7:0] v, output logic [11:0] res, output int lat);
    in_valid = 1'b1;
    bin      = v;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bcd;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; bin = 8'd77; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    $display("reset: out_valid=%b bcd=%h in_ready=%b", out_valid, bcd, in_ready);
  endtask

  task automatic test_zero();
    logic [11:0] res; int lat;
    out_ready = 1'b1;
    start_and_wait(8'd0, res, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
    checks++;
    if (res !== 12'h000) begin errors++; $display("FAIL zero_bcd got %h want 000", res); end
    @(negedge clk);
    $display("conv bin=0 bcd=%h lat=%0d", res, lat);
  endtask

  task automatic test_225();
    logic [11:0] res; int lat;
    out_ready = 1'b1;
    start_and_wait(8'd225, res, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL p225_latency got %0d want 8", lat); end
    checks++;
    if (res !== 12'h225) begin errors++; $display("FAIL p225_bcd got %h want 225", res); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL p225_ready_in_done got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL p225_ready_after got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL p225_valid_after got %b want 0", out_valid); end
    $display("conv bin=225 bcd=%h lat=%0d", res, lat);
  endtask

  task automatic test_backpressure();
    logic [11:0] res; int lat; int bad;
    out_ready = 1'b0;
    start_and_wait(8'd255, res, lat);
    checks++;
    if (lat !== 8 || res !== 12'h255) begin
      errors++; $display("FAIL bp_result got %h lat %0d want 255 lat 8", res, lat);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || bcd !== 12'h255 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++;
    if (bcd !== 12'h255) begin errors++; $display("FAIL bp_bcd_kept got %h want 255", bcd); end
    $display("conv bin=255 backpressure bcd=%h", bcd);
  endtask

  task automatic test_reset_abort();
    logic [11:0] res; int lat; int pulses;
    out_ready = 1'b1;
    in_valid = 1'b1; bin = 8'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; bin = 8'd50;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || bcd !== 12'h000) begin
      errors++; $display("FAIL abort_state got valid %b bcd %h want 0 000", out_valid, bcd);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_no_pulse got %0d valid cycles want 0", pulses); end
    start_and_wait(8'd7, res, lat);
    checks++;
    if (res !== 12'h007 || lat !== 8) begin
      errors++; $display("FAIL abort_recover got %h lat %0d want 007 lat 8", res, lat);
    end
    @(negedge clk);
    $display("conv bin=99 aborted, then bin=7 bcd=%h", res);
  endtask

  task automatic test_back_to_back();
    logic [11:0] res; int low; int lat; logic [11:0] res42;
    out_ready = 1'b1;
    in_valid = 1'b1; bin = 8'd42;
    @(negedge clk);
    low = 0; res42 = 12'hFFF;
    while (!in_ready && low < 40) begin
      if (out_valid) res42 = bcd;
      bin = 8'($urandom_range(0, 255));
      low++;
      @(negedge clk);
    end
    checks++;
    if (res42 !== 12'h042) begin errors++; $display("FAIL b2b_result got %h want 042", res42); end
    checks++;
    if (low !== 9) begin errors++; $display("FAIL b2b_ready_low got %0d want 9", low); end
    start_and_wait(8'd123, res, lat);
    checks++;
    if (res !== 12'h123 || lat !== 8) begin
      errors++; $display("FAIL b2b_next got %h lat %0d want 123 lat 8", res, lat);
    end
    @(negedge clk);
    $display("conv bin=42 with churning bin bcd=%h, next bcd=%h", res42, res);
  endtask

  task automatic test_sweep();
    logic [11:0] res; int lat; int bad;
    out_ready = 1'b1;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      start_and_wait(8'(v), res, lat);
      checks++;
      if (res !== dec_digits(v) || lat !== 8) begin
        errors++; bad++;
        $display("FAIL sweep_%0d got %h lat %0d want %h lat 8", v, res, lat, dec_digits(v));
      end else begin
        $display("sweep bin=%0d bcd=%h", v, res);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; bin = '0; out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero();
    test_225();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
